stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM and BCD time base for the stopwatch. Consumes the one-cycle
//  100 Hz tick pulse from the clock divider and start/stop, lap and clear
//  button pulses. Sequences run/pause/lap/clear and keeps mm:ss.cc in BCD.
//  Drives the display path with either the live time or a frozen lap time.
// PARAMETERS
//  MIN_MAX   59   highest minute value before wrap to 00:00.00 (BCD-encodable, <=99)
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  rst_n         in   1  asynchronous, active-low reset
//  tick_100hz    in   1  one-cycle pulse at 100 Hz from clock divider
//  start_stop_p  in   1  one-cycle pulse, debounced start/stop button
//  lap_p         in   1  one-cycle pulse, debounced lap button
//  clear_p       in   1  one-cycle pulse, debounced clear button
//  disp_mm       out  8  displayed minutes, BCD {tens,ones}
//  disp_ss       out  8  displayed seconds, BCD {tens,ones}
//  disp_cc       out  8  displayed hundredths, BCD {tens,ones}
//  running       out  1  1 in RUN or LAP
//  lap_active    out  1  1 in LAP (display frozen)
//  overflow      out  1  sticky; set on wrap past MIN_MAX:59.99
// BEHAVIOUR
//  - Reset (rst_n=0, async, immediate): state=IDLE; live and lap counters=0;
//    all outputs 0. Reset mid-run takes effect with no clock edge needed.
//  - States IDLE, RUN, PAUSE, LAP. Same-cycle pulse priority:
//    clear_p > start_stop_p > lap_p. Only the winning pulse acts; others dropped.
//    IDLE : start_stop -> RUN; lap, clear ignored.
//    RUN  : start_stop -> PAUSE; lap -> LAP, lap latch <= live time
//           (value after this cycle's tick, if any); clear ignored.
//    LAP  : lap -> RUN; start_stop -> PAUSE (lap released, live shown); clear ignored.
//    PAUSE: start_stop -> RUN; clear -> IDLE, live counter, lap latch, overflow <= 0;
//           lap ignored.
//  - Count enable = tick_100hz AND current (registered) state in {RUN,LAP}.
//    Tick in same cycle as start from IDLE/PAUSE: not counted.
//    Tick in same cycle as stop from RUN/LAP: counted.
//  - Arithmetic: cc 00..99, ss 00..59, mm 00..MIN_MAX, each two BCD digits;
//    ones 9->0 carries to tens; cc 99->00 carries ss; ss 59->00 carries mm.
//    At MIN_MAX:59.99 a tick wraps to 00:00.00, sets overflow; counting continues.
//  - overflow cleared only by clear (PAUSE->IDLE) or reset.
//  - Display: disp_* = lap latch when state==LAP, else live counter. Mux of
//    registers, no extra latency: new count visible the cycle after the tick edge.
//  - running/lap_active decoded from the state register (registered, glitch-free).
// STRUCTURE
//  - Package stopwatch_pkg: state encodings (IDLE/RUN/PAUSE/LAP localparams),
//    BCD_W=4, CC_MAX=99, SS_MAX=59, shared by FSM and bench.
//  - Sub-module bcd_mod_counter #(MAX) (en, clr, out[7:0], carry): two-digit BCD
//    counter, wraps at MAX, carry=en&&(out==MAX). Three instances (cc, ss, mm),
//    carry chained into next instance's en. FSM and lap latch live in top.
// TESTING
//  1. Reset, start_stop, 150 ticks -> disp 00:01.50, running=1, lap_active=0.
//  2. Start, 30 ticks, lap, 20 ticks -> disp 00:00.30, lap_active=1; lap again
//     -> disp 00:00.50, lap_active=0.
//  3. Start, 10 ticks, stop, 5 ticks -> disp 00:00.10, running=0; clear ->
//     00:00.00, state IDLE; clear in RUN -> no effect.
//  4. Run to 59:59.99, one tick -> 00:00.00, overflow=1, still running;
//     stop + clear -> overflow=0.
//  5. PAUSE with clear_p+start_stop_p same cycle -> IDLE, all zero; tick coincident
//     with stop in RUN at 00:00.07 -> PAUSE showing 00:00.08.
//  6. Run to 00:12.34, drop rst_n between clock edges -> all outputs 0 immediately;
//     after release, ticks ignored until start_stop.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding, BCD limits and digit helpers for the stopwatch control path.
package stopwatch_pkg;

    localparam int BCD_W  = 4;
    localparam int CC_MAX = 99;
    localparam int SS_MAX = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    function automatic logic [7:0] to_bcd(input int v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction

    // Next value of a two-digit BCD counter that wraps to zero after max_bcd.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max_bcd);
        logic [7:0] r;
        if (v == max_bcd) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; one-cycle update, carry is combinational.
// No backpressure: counts whenever en is high, clr wins over en.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] out,
    output logic       carry
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else if (clr) begin
            cnt_q <= 8'h00;
        end else if (en) begin
            cnt_q <= bcd_step(cnt_q, MAX_BCD);
        end
    end

    assign out   = cnt_q;
    assign carry = en && (cnt_q == MAX_BCD);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, mm:ss.cc BCD time base and lap latch; display follows a tick by one edge.
// No backpressure: every tick and button pulse is acted on or dropped in its own cycle.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_100hz,
    input  logic       start_stop_p,
    input  logic       lap_p,
    input  logic       clear_p,
    output logic [7:0] disp_mm,
    output logic [7:0] disp_ss,
    output logic [7:0] disp_cc,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam logic [7:0] CC_MAX_BCD = to_bcd(CC_MAX);
    localparam logic [7:0] SS_MAX_BCD = to_bcd(SS_MAX);
    localparam logic [7:0] MM_MAX_BCD = to_bcd(MIN_MAX);

    state_t      state_q, state_d;
    logic        running_q, lap_active_q, overflow_q;
    logic [23:0] lap_q;
    logic [23:0] live, live_nxt;
    logic [7:0]  cc, ss, mm;
    logic        cc_carry, ss_carry, mm_carry;
    logic        cnt_en, live_clr;
    logic        do_clr, do_ss, do_lap;

    // Only the highest-priority pulse of a cycle is allowed to act.
    assign do_clr = clear_p;
    assign do_ss  = start_stop_p && !clear_p;
    assign do_lap = lap_p && !start_stop_p && !clear_p;

    assign cnt_en   = tick_100hz && ((state_q == ST_RUN) || (state_q == ST_LAP));
    assign live_clr = do_clr && (state_q == ST_PAUSE);

    bcd_mod_counter #(.MAX(CC_MAX)) u_cc (
        .clk(clk), .rst_n(rst_n), .en(cnt_en), .clr(live_clr), .out(cc), .carry(cc_carry)
    );
    bcd_mod_counter #(.MAX(SS_MAX)) u_ss (
        .clk(clk), .rst_n(rst_n), .en(cc_carry), .clr(live_clr), .out(ss), .carry(ss_carry)
    );
    bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
        .clk(clk), .rst_n(rst_n), .en(ss_carry), .clr(live_clr), .out(mm), .carry(mm_carry)
    );

    assign live = {mm, ss, cc};
    // The lap latch must capture the time including a coincident tick.
    assign live_nxt = {ss_carry ? bcd_step(mm, MM_MAX_BCD) : mm,
                       cc_carry ? bcd_step(ss, SS_MAX_BCD) : ss,
                       cnt_en   ? bcd_step(cc, CC_MAX_BCD) : cc};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (do_ss) state_d = ST_RUN;
            ST_RUN:   if (do_ss) state_d = ST_PAUSE; else if (do_lap) state_d = ST_LAP;
            ST_LAP:   if (do_ss) state_d = ST_PAUSE; else if (do_lap) state_d = ST_RUN;
            ST_PAUSE: if (do_clr) state_d = ST_IDLE; else if (do_ss) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            lap_q        <= '0;
        end else begin
            state_q      <= state_d;
            running_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
            lap_active_q <= (state_d == ST_LAP);
            if (live_clr) begin
                overflow_q <= 1'b0;
                lap_q      <= '0;
            end else begin
                if (mm_carry) overflow_q <= 1'b1;
                if ((state_q == ST_RUN) && do_lap) lap_q <= live_nxt;
            end
        end
    end

    assign {disp_mm, disp_ss, disp_cc} = (state_q == ST_LAP) ? lap_q : live;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised and directed bench for stopwatch_ctrl against a centisecond-count model.
module tb_stopwatch_ctrl;

    // Small minute limit keeps the wrap reachable in a short run.
    localparam int MM_LIM = 3;
    localparam int WRAP   = (MM_LIM + 1) * 6000;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_100hz = 1'b0, start_stop_p = 1'b0, lap_p = 1'b0, clear_p = 1'b0;
    logic [7:0] disp_mm, disp_ss, disp_cc;
    logic       running, lap_active, overflow;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int m_mode, m_t, m_lap;
    bit m_ovf;

    stopwatch_ctrl #(.MIN_MAX(MM_LIM)) dut (
        .clk(clk), .rst_n(rst_n), .tick_100hz(tick_100hz), .start_stop_p(start_stop_p),
        .lap_p(lap_p), .clear_p(clear_p), .disp_mm(disp_mm), .disp_ss(disp_ss),
        .disp_cc(disp_cc), .running(running), .lap_active(lap_active), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int dec2(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int shown();
        return (m_mode == M_LAP) ? m_lap : m_t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_t    = 0;
        m_lap  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update(input bit tk, input bit s, input bit l, input bit c);
        if (tk && (m_mode == M_RUN || m_mode == M_LAP)) begin
            m_t = m_t + 1;
            if (m_t == WRAP) begin
                m_t   = 0;
                m_ovf = 1'b1;
            end
        end
        if (c) begin
            if (m_mode == M_PAUSE) begin
                m_mode = M_IDLE;
                m_t    = 0;
                m_lap  = 0;
                m_ovf  = 1'b0;
            end
        end else if (s) begin
            m_mode = (m_mode == M_IDLE || m_mode == M_PAUSE) ? M_RUN : M_PAUSE;
        end else if (l) begin
            if (m_mode == M_RUN) begin
                m_mode = M_LAP;
                m_lap  = m_t;
            end else if (m_mode == M_LAP) begin
                m_mode = M_RUN;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_mm", disp_mm, dec2(shown() / 6000));
            chk("cyc_ss", disp_ss, dec2((shown() / 100) % 60));
            chk("cyc_cc", disp_cc, dec2(shown() % 100));
            chk("cyc_running", running, (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0);
            chk("cyc_lap_active", lap_active, (m_mode == M_LAP) ? 1 : 0);
            chk("cyc_overflow", overflow, m_ovf ? 1 : 0);
        end
    end

    task automatic step(input bit tk, input bit s, input bit l, input bit c);
        tick_100hz   = tk;
        start_stop_p = s;
        lap_p        = l;
        clear_p      = c;
        @(posedge clk);
        model_update(tk, s, l, c);
        #1;
        tick_100hz   = 1'b0;
        start_stop_p = 1'b0;
        lap_p        = 1'b0;
        clear_p      = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stop_clear();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic lit_time(input string name, input int mm, input int ss, input int cc);
        chk({name, "_mm"}, disp_mm, mm);
        chk({name, "_ss"}, disp_ss, ss);
        chk({name, "_cc"}, disp_cc, cc);
    endtask

    // Reset dropped mid-cycle; outputs must clear with no clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        lit_time("async_rst", 8'h00, 8'h00, 8'h00);
        chk("async_rst_running", running, 0);
        chk("async_rst_lap", lap_active, 0);
        chk("async_rst_ovf", overflow, 0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #12;
        lit_time("reset", 8'h00, 8'h00, 8'h00);
        chk("reset_running", running, 0);
        chk("reset_ovf", overflow, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(150);
        lit_time("t1", 8'h00, 8'h01, 8'h50);
        chk("t1_running", running, 1);
        chk("t1_lap", lap_active, 0);
        stop_clear();

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(30);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(20);
        lit_time("t2_frozen", 8'h00, 8'h00, 8'h30);
        chk("t2_lap_on", lap_active, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lit_time("t2_release", 8'h00, 8'h00, 8'h50);
        chk("t2_lap_off", lap_active, 0);
        stop_clear();

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        lit_time("t3_paused", 8'h00, 8'h00, 8'h10);
        chk("t3_running", running, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit_time("t3_cleared", 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        lit_time("t3_clr_in_run", 8'h00, 8'h00, 8'h03);
        chk("t3_clr_in_run_running", running, 1);
        stop_clear();

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(WRAP - 1);
        lit_time("t4_max", 8'h03, 8'h59, 8'h99);
        chk("t4_ovf_before", overflow, 0);
        ticks(1);
        lit_time("t4_wrap", 8'h00, 8'h00, 8'h00);
        chk("t4_ovf_set", overflow, 1);
        chk("t4_running", running, 1);
        ticks(2);
        chk("t4_ovf_sticky", overflow, 1);
        stop_clear();
        chk("t4_ovf_cleared", overflow, 0);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        lit_time("t5_stop_tick", 8'h00, 8'h00, 8'h08);
        chk("t5_paused", running, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        lit_time("t5_clr_wins", 8'h00, 8'h00, 8'h00);
        chk("t5_idle", running, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        ticks(4);
        lit_time("t5_start_tick", 8'h00, 8'h00, 8'h04);
        stop_clear();

        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1234);
        lit_time("t6_run", 8'h00, 8'h12, 8'h34);
        async_reset();
        ticks(20);
        lit_time("t6_idle_ticks", 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        lit_time("t6_restart", 8'h00, 8'h00, 8'h05);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 1) == 1,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0);
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
